fp_addsub_round_pipe: RTL and testbench

Registered rounding and packing stage that sits directly downstream of the normalization shift stage 2 in the FP adder/subtractor. It consumes the normalized mantissa, adjusted exponent, guard/round/sticky bits and the zero and negative-exponent flags. It applies round-to-nearest-even, handles mantissa carry-out, overflow to infinity and flush-to-zero, and packs the IEEE-754 single-precision word. A valid/ready handshake with a 2-entry skid buffer lets the adder pipeline stall without losing data. Sticky exception flags accumulate until software clears them.

---
 rtl/fp_addsub_pkg.sv | 31 +++
 rtl/fp_addsub_round_pipe_if.sv | 36 +++
 rtl/fp_addsub_round_core.sv | 69 ++++++
 rtl/fp_addsub_round_pipe.sv | 126 ++++++++++++
 tb/tb_fp_addsub_round_pipe.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP adder/subtractor rounding and packing stage.
package fp_addsub_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int EXP_MAX = 255;

    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
    localparam logic [31:0]      POS_ZERO = 32'h0000_0000;
    localparam logic [EXP_W-1:0] INF_EXP  = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

    typedef struct packed {
        fp_word_t word;
        logic     ovf;
        logic     unf;
        logic     inx;
    } rnd_item_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/fp_addsub_round_pipe_if.sv
// Handshake bus between normalization stage 2, the rounding stage and its consumer.
interface fp_addsub_round_pipe_if;
    import fp_addsub_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [MAN_W-1:0]        in_norm_m;
    logic signed [EXP_W:0]   in_norm_e;
    logic                    in_neg_e;
    logic                    in_zero_sum;
    logic                    in_fg;
    logic                    in_r;
    logic                    in_s;
    logic                    in_special;
    logic [31:0]             in_special_word;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_result;
    logic                    out_ovf;
    logic                    out_unf;
    logic                    out_inx;

    modport slave (
        input  in_valid, in_sign, in_norm_m, in_norm_e, in_neg_e, in_zero_sum,
               in_fg, in_r, in_s, in_special, in_special_word, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_inx
    );

    modport master (
        output in_valid, in_sign, in_norm_m, in_norm_e, in_neg_e, in_zero_sum,
               in_fg, in_r, in_s, in_special, in_special_word, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inx
    );

endinterface

// File: rtl/fp_addsub_round_core.sv
// Combinational round-to-nearest-even, exception priority and IEEE-754 packing.
module fp_addsub_round_core
    import fp_addsub_pkg::fp_word_t;
    import fp_addsub_pkg::INF_EXP;
    import fp_addsub_pkg::EXP_MAX;
    import fp_addsub_pkg::POS_ZERO;
#(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8
) (
    input  logic                     sign_i,
    input  logic [MAN_W-1:0]         norm_m_i,
    input  logic signed [EXP_W:0]    norm_e_i,
    input  logic                     neg_e_i,
    input  logic                     zero_sum_i,
    input  logic                     fg_i,
    input  logic                     r_i,
    input  logic                     s_i,
    input  logic                     special_i,
    input  logic [EXP_W+MAN_W:0]     special_word_i,
    output fp_word_t                 result_o,
    output logic                     ovf_o,
    output logic                     unf_o,
    output logic                     inx_o
);

    localparam logic [EXP_W:0] EXP_LIM = (EXP_W+1)'(EXP_MAX);

    logic                  round_up;
    logic                  inexact;
    logic                  carry;
    logic [MAN_W:0]        man_rnd;
    logic signed [EXP_W:0] exp_fin;
    logic [EXP_W:0]        exp_u;

    always_comb begin
        round_up = fg_i & (r_i | s_i | norm_m_i[0]);
        inexact  = fg_i | r_i | s_i;
        man_rnd  = {1'b0, norm_m_i} + {{MAN_W{1'b0}}, round_up};
        carry    = man_rnd[MAN_W];
        // Mantissa carry-out bumps the exponent; done at full 9-bit width so 254+1 is caught below.
        exp_fin  = norm_e_i + $signed({{EXP_W{1'b0}}, carry});
        exp_u    = $unsigned(exp_fin);

        result_o.sign = sign_i;
        result_o.exp  = exp_u[EXP_W-1:0];
        result_o.man  = carry ? '0 : man_rnd[MAN_W-1:0];
        ovf_o         = 1'b0;
        unf_o         = 1'b0;
        inx_o         = inexact;

        if (special_i) begin
            result_o = special_word_i;
            inx_o    = 1'b0;
        end else if (zero_sum_i) begin
            result_o = POS_ZERO;
            inx_o    = 1'b0;
        end else if (neg_e_i || exp_u == '0) begin
            result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
            unf_o    = 1'b1;
            inx_o    = 1'b1;
        end else if (exp_u >= EXP_LIM) begin
            result_o = {sign_i, INF_EXP, {MAN_W{1'b0}}};
            ovf_o    = 1'b1;
            inx_o    = 1'b1;
        end
    end

endmodule

// File: rtl/fp_addsub_round_pipe.sv
// Rounding/packing stage with a 2-entry skid buffer and sticky exception flags.
module fp_addsub_round_pipe
    import fp_addsub_pkg::fp_word_t;
    import fp_addsub_pkg::rnd_item_t;
    import fp_addsub_pkg::skid_state_t;
    import fp_addsub_pkg::SKID_EMPTY;
    import fp_addsub_pkg::SKID_ONE;
    import fp_addsub_pkg::SKID_FULL;
#(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    fp_addsub_round_pipe_if.slave       bus,
    input  logic                        flag_clr,
    output logic                        flag_ovf,
    output logic                        flag_unf,
    output logic                        flag_inx
);

    fp_word_t    core_word;
    logic        core_ovf;
    logic        core_unf;
    logic        core_inx;
    rnd_item_t   core_item;
    rnd_item_t   main_q, main_d;
    rnd_item_t   skid_q, skid_d;
    skid_state_t state_q, state_d;
    logic        flag_ovf_q, flag_ovf_d;
    logic        flag_unf_q, flag_unf_d;
    logic        flag_inx_q, flag_inx_d;
    logic        accept;
    logic        pop;

    fp_addsub_round_core #(
        .MAN_W (MAN_W),
        .EXP_W (EXP_W)
    ) u_core (
        .sign_i         (bus.in_sign),
        .norm_m_i       (bus.in_norm_m),
        .norm_e_i       (bus.in_norm_e),
        .neg_e_i        (bus.in_neg_e),
        .zero_sum_i     (bus.in_zero_sum),
        .fg_i           (bus.in_fg),
        .r_i            (bus.in_r),
        .s_i            (bus.in_s),
        .special_i      (bus.in_special),
        .special_word_i (bus.in_special_word),
        .result_o       (core_word),
        .ovf_o          (core_ovf),
        .unf_o          (core_unf),
        .inx_o          (core_inx)
    );

    assign core_item = {core_word, core_ovf, core_unf, core_inx};
    assign accept    = bus.in_valid & bus.in_ready;
    assign pop       = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SKID_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
            flag_inx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            flag_ovf_q <= flag_ovf_d;
            flag_unf_q <= flag_unf_d;
            flag_inx_q <= flag_inx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    main_d  = core_item;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && pop) begin
                    main_d = core_item;
                end else if (accept) begin
                    skid_d  = core_item;
                    state_d = SKID_FULL;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase

        // A transfer in the same cycle as flag_clr still records its flags.
        flag_ovf_d = (flag_clr ? 1'b0 : flag_ovf_q) | (pop & main_q.ovf);
        flag_unf_d = (flag_clr ? 1'b0 : flag_unf_q) | (pop & main_q.unf);
        flag_inx_d = (flag_clr ? 1'b0 : flag_inx_q) | (pop & main_q.inx);
    end

    always_comb begin
        bus.in_ready   = (state_q != SKID_FULL);
        bus.out_valid  = (state_q != SKID_EMPTY);
        bus.out_result = main_q.word;
        bus.out_ovf    = main_q.ovf;
        bus.out_unf    = main_q.unf;
        bus.out_inx    = main_q.inx;
        flag_ovf       = flag_ovf_q;
        flag_unf       = flag_unf_q;
        flag_inx       = flag_inx_q;
    end

endmodule

// File: tb/tb_fp_addsub_round_pipe.sv
// Directed-vector bench for the FP rounding/packing stage and its skid buffer.
module tb_fp_addsub_round_pipe;
    import fp_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flag_clr;
    logic flag_ovf;
    logic flag_unf;
    logic flag_inx;
    int   checks   = 0;
    int   failures = 0;

    fp_addsub_round_pipe_if bus ();

    fp_addsub_round_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flag_clr (flag_clr),
        .flag_ovf (flag_ovf),
        .flag_unf (flag_unf),
        .flag_inx (flag_inx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sign, input logic [22:0] m, input logic [8:0] e,
                         input logic neg, input logic zero, input logic fg, input logic r,
                         input logic s, input logic special, input logic [31:0] word);
        bus.in_valid        = 1'b1;
        bus.in_sign         = sign;
        bus.in_norm_m       = m;
        bus.in_norm_e       = e;
        bus.in_neg_e        = neg;
        bus.in_zero_sum     = zero;
        bus.in_fg           = fg;
        bus.in_r            = r;
        bus.in_s            = s;
        bus.in_special      = special;
        bus.in_special_word = word;
    endtask

    task automatic idle;
        drive(1'b0, 23'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        bus.out_ready = 1'b1;
        flag_clr      = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.out_result !== 32'h0) begin
            failures++;
            $display("FAIL reset_out_result got=%h exp=00000000", bus.out_result);
        end
        checks++;
        if ({flag_ovf, flag_unf, flag_inx, bus.out_ovf, bus.out_unf, bus.out_inx} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {flag_ovf, flag_unf, flag_inx, bus.out_ovf, bus.out_unf, bus.out_inx});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rounding;
        logic [22:0] vm  [5] = '{23'h7FFFFF, 23'h000000, 23'h000000, 23'h000001, 23'h000002};
        logic [8:0]  ve  [5] = '{9'h07F, 9'h07F, 9'h07F, 9'h080, 9'h07F};
        logic        vfg [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        vr  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        vs  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] xr  [5] = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h40000001, 32'h3F800002};
        logic        xi  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, vm[i], ve[i], 1'b0, 1'b0, vfg[i], vr[i], vs[i], 1'b0, 32'h0);
            tick();
            idle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== xr[i]) begin
                failures++;
                $display("FAIL round_%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_result, xr[i]);
            end
            checks++;
            if (bus.out_inx !== xi[i] || bus.out_ovf !== 1'b0 || bus.out_unf !== 1'b0) begin
                failures++;
                $display("FAIL round_flags_%0d got=ovf%b unf%b inx%b exp=ovf0 unf0 inx%b",
                         i, bus.out_ovf, bus.out_unf, bus.out_inx, xi[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow_flags;
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        checks++;
        if (flag_inx !== 1'b0) begin
            failures++;
            $display("FAIL clr_inx got=%b exp=0", flag_inx);
        end
        drive(1'b1, 23'h7FFFFF, 9'h0FE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        checks++;
        if (bus.out_result !== 32'hFF800000 || bus.out_ovf !== 1'b1 || bus.out_inx !== 1'b1) begin
            failures++;
            $display("FAIL ovf_result got=%h ovf%b inx%b exp=ff800000 ovf1 inx1",
                     bus.out_result, bus.out_ovf, bus.out_inx);
        end
        checks++;
        if (flag_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky_early got=%b exp=0", flag_ovf);
        end
        tick();
        checks++;
        if (flag_ovf !== 1'b1 || flag_inx !== 1'b1 || flag_unf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky got=ovf%b unf%b inx%b exp=ovf1 unf0 inx1", flag_ovf, flag_unf, flag_inx);
        end
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        checks++;
        if (flag_ovf !== 1'b0 || flag_inx !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=ovf%b inx%b exp=ovf0 inx0", flag_ovf, flag_inx);
        end
    endtask

    task automatic test_underflow_zero_special;
        logic        vsg [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [22:0] vm  [4] = '{23'h000000, 23'h123456, 23'h000000, 23'h000005};
        logic [8:0]  ve  [4] = '{9'h1FF, 9'h07F, 9'h07F, 9'h000};
        logic        vn  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        vz  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        vsp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] xr  [4] = '{32'h80000000, 32'h00000000, 32'h7FC00000, 32'h00000000};
        logic [2:0]  xf  [4] = '{3'b011, 3'b000, 3'b000, 3'b011};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(vsg[i], vm[i], ve[i], vn[i], vz[i], 1'b1, 1'b0, 1'b0, vsp[i], QNAN);
            tick();
            idle();
            checks++;
            if (bus.out_result !== xr[i] || {bus.out_ovf, bus.out_unf, bus.out_inx} !== xf[i]) begin
                failures++;
                $display("FAIL excep_%0d got=%h ovf/unf/inx=%b exp=%h %b", i, bus.out_result,
                         {bus.out_ovf, bus.out_unf, bus.out_inx}, xr[i], xf[i]);
            end
            tick();
        end
        drive(1'b0, 23'h7FFFFF, 9'h0FE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        drive(1'b1, 23'h0, 9'h1F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        checks++;
        if ({flag_ovf, flag_unf, flag_inx} !== 3'b011) begin
            failures++;
            $display("FAIL clr_with_transfer got=ovf/unf/inx=%b exp=011", {flag_ovf, flag_unf, flag_inx});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got [$];
        logic [31:0] exp_v [3] = '{32'h3F800001, 32'h3F800002, 32'h3F800003};
        logic [31:0] val;
        logic        c_take;
        bus.out_ready = 1'b0;
        drive(1'b0, 23'h000001, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 23'h000002, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_result !== exp_v[0]) begin
            failures++;
            $display("FAIL bp_full got=rdy%b %h exp=rdy0 %h", bus.in_ready, bus.out_result, exp_v[0]);
        end
        drive(1'b0, 23'h000003, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== exp_v[0]) begin
            failures++;
            $display("FAIL bp_hold got=rdy%b vld%b %h exp=rdy0 vld1 %h",
                     bus.in_ready, bus.out_valid, bus.out_result, exp_v[0]);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_result);
            c_take = bus.in_valid & bus.in_ready;
            tick();
            if (c_take) idle();
            if (!bus.out_valid && got.size() >= 3) break;
        end
        checks++;
        if (got.size() != 3 || bus.in_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_count got=%0d items c_pending=%b exp=3 items c_pending=0", got.size(), bus.in_valid);
        end
        for (int i = 0; i < 3; i++) begin
            val = (i < got.size()) ? got[i] : 32'hDEADBEEF;
            checks++;
            if (val !== exp_v[i]) begin
                failures++;
                $display("FAIL bp_order_%0d got=%h exp=%h", i, val, exp_v[i]);
            end
        end
        idle();
    endtask

    task automatic test_async_reset;
        bus.out_ready = 1'b0;
        drive(1'b0, 23'h000011, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 23'h000022, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL arst_prefull got=rdy%b exp=rdy0", bus.in_ready);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'h0) begin
            failures++;
            $display("FAIL arst_immediate got=vld%b rdy%b %h exp=vld0 rdy1 00000000",
                     bus.out_valid, bus.in_ready, bus.out_result);
        end
        #2;
        rst = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        drive(1'b0, 23'h000044, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h40800044) begin
            failures++;
            $display("FAIL arst_first_item got=vld%b %h exp=vld1 40800044", bus.out_valid, bus.out_result);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_drain got=vld%b exp=vld0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_overflow_flags();
        test_underflow_zero_special();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
